rocc_vec_reduce: RTL and testbench
==================================

# rocc_vec_reduce

Parametrised RoCC accelerator that streams a vector of xLen-bit words from the L1 data cache and reduces it (wrapping sum, XOR, or unsigned max) into a single word returned to the core on the RoCC response channel. Sits directly on the Rocket RoCC port, in place of the current stub top-level. It generalises that top-level with real command decode, multiple outstanding memory requests, nack replay, and selectable reduction mode.

## Interface

Parameters:
- xLen, 64, data/register width; memory word size
- coreMaxAddrBits, 40, memory address width
- dcacheReqTagBits, 9, memory tag width
- MAX_OUT, 4, maximum outstanding memory requests (power of two, 2..16)
- CNT_W, 16, element-count width

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- rocc_cmd_valid / rocc_cmd_ready  input / output  1 / 1  command handshake
- rocc_cmd_bits_inst_funct  input  7  0 = SET_BASE, 1 = RUN
- rocc_cmd_bits_inst_rd  input  5  destination register
- rocc_cmd_bits_inst_xd  input  1  response expected
- rocc_cmd_bits_rs1 / rocc_cmd_bits_rs2  input  xLen  operands
- rocc_resp_valid / rocc_resp_ready  output / input  1 / 1  response handshake
- rocc_resp_bits_rd  output  5  echoed rd
- rocc_resp_bits_data  output  xLen  reduction result
- rocc_mem_req_valid / rocc_mem_req_ready  output / input  1 / 1  memory request handshake
- rocc_mem_req_bits_addr  output  coreMaxAddrBits  word address
- rocc_mem_req_bits_tag  output  dcacheReqTagBits  slot index, zero-extended
- rocc_mem_req_bits_cmd  output  5  constant 5'b00000 (M_XRD)
- rocc_mem_req_bits_size  output  2  constant 2'b11
- rocc_mem_req_bits_signed, _phys, _no_alloc, _no_xcpt  output  1  constant 0
- rocc_mem_s2_nack  input  1  request issued two cycles earlier was rejected
- rocc_mem_resp_valid  input  1  load data valid
- rocc_mem_resp_bits_tag  input  dcacheReqTagBits  returning slot
- rocc_mem_resp_bits_data  input  xLen  load data
- rocc_busy  output  1  high whenever state != IDLE
- rocc_interrupt  output  1  constant 0

## Operation

- Registers: base (coreMaxAddrBits), remaining-to-issue, remaining-to-receive (CNT_W), mode (2), acc (xLen), rd (5), xd (1), per-slot pending bit and address, 2-deep issued-slot pipe for nack tracking.
- States: IDLE, RUN, RESP.
- IDLE: cmd_ready = 1. SET_BASE: base <= rs1[coreMaxAddrBits-1:0], no response, stays IDLE. RUN: count <= rs1[CNT_W-1:0], mode <= rs2[1:0], rd/xd latched, acc <= identity (0 for all modes) -> RUN. Any other funct: accepted, discarded.
- RUN with count 0: go straight to RESP (if xd) or IDLE next cycle.
- RUN: issue while remaining-to-issue > 0 and a free slot exists (lowest free index); addr = base + 8*issued-index; mem_req fires on valid & ready; slot marked pending, address stored.
- Nack: s2_nack refers to the slot fired two cycles earlier; that slot is re-queued and reissued at its stored address with priority over new issues. Nacked requests never return data.
- Response: on resp_valid with pending tag, acc <= acc + data (mode 0, mod 2^xLen), acc ^ data (mode 1), unsigned max (mode 2; mode 3 treated as 2); slot freed, remaining-to-receive decremented. Out-of-order returns allowed.
- Remaining-to-receive reaches 0 -> RESP if xd, else IDLE. base <= base + 8*count on completion.
- RESP: resp_valid = 1, data = acc, rd = latched rd; leaves to IDLE on resp_ready.
- Responses with a non-pending tag are ignored.

## Timing

- Reset: state IDLE, all slots free, acc/base 0; cmd_ready 1, resp_valid 0, mem_req_valid 0, busy 0, interrupt 0. Reset mid-RUN abandons outstanding loads; late responses are ignored as non-pending.
- Command to first mem_req_valid: 1 cycle.
- At most one request fired and one response absorbed per cycle; simultaneous free and allocate of one slot is legal.
- mem_req_valid held with stable addr/tag until ready.
- Last response to resp_valid: 1 cycle. Zero-count RUN to resp_valid: 1 cycle.
- cmd_ready is 0 in RUN and RESP.

## Test plan

- SET_BASE 0x1000, RUN count 4 mode 0 over words 1,2,3,4, xd=1, rd=5 -> resp rd 5 data 10; addresses 0x1000,0x1008,0x1010,0x1018.
- Mode 1 over 0xFF,0x0F -> 0xF0; mode 2 over 0x1, 0xFFFF_FFFF_FFFF_FFFF, 0x7 -> 0xFFFF_FFFF_FFFF_FFFF; mode 0 over 0xFFFF_FFFF_FFFF_FFFF, 2 -> 1.
- Count 10, memory model returns reversed order and holds mem_req_ready low every other cycle -> never more than MAX_OUT pending; sum correct.
- s2_nack on the second request -> same address reissued, each address read exactly once, correct result.
- Count 0 with xd=1 -> resp data 0 one cycle after command; RUN with xd=0 -> no response, busy falls after last load.
- Reset asserted with 3 loads outstanding, then stale responses -> outputs at reset values, next RUN correct.

Source files
------------

// File: rtl/rocc_vec_reduce.sv
// rocc_vec_reduce: RoCC accelerator that streams xLen-bit words from the L1
// data cache and folds them into one word (wrapping sum, XOR or unsigned max).
// Up to MAX_OUT loads are in flight, each identified by its slot index as tag.
// A load rejected by s2_nack is replayed from the address stored in its slot.
module rocc_vec_reduce #(
  parameter int xLen             = 64,
  parameter int coreMaxAddrBits  = 40,
  parameter int dcacheReqTagBits = 9,
  parameter int MAX_OUT          = 4,
  parameter int CNT_W            = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rocc_cmd_valid,
  output logic                        rocc_cmd_ready,
  input  logic [6:0]                  rocc_cmd_bits_inst_funct,
  input  logic [4:0]                  rocc_cmd_bits_inst_rd,
  input  logic                        rocc_cmd_bits_inst_xd,
  input  logic [xLen-1:0]             rocc_cmd_bits_rs1,
  input  logic [xLen-1:0]             rocc_cmd_bits_rs2,
  output logic                        rocc_resp_valid,
  input  logic                        rocc_resp_ready,
  output logic [4:0]                  rocc_resp_bits_rd,
  output logic [xLen-1:0]             rocc_resp_bits_data,
  output logic                        rocc_mem_req_valid,
  input  logic                        rocc_mem_req_ready,
  output logic [coreMaxAddrBits-1:0]  rocc_mem_req_bits_addr,
  output logic [dcacheReqTagBits-1:0] rocc_mem_req_bits_tag,
  output logic [4:0]                  rocc_mem_req_bits_cmd,
  output logic [1:0]                  rocc_mem_req_bits_size,
  output logic                        rocc_mem_req_bits_signed,
  output logic                        rocc_mem_req_bits_phys,
  output logic                        rocc_mem_req_bits_no_alloc,
  output logic                        rocc_mem_req_bits_no_xcpt,
  input  logic                        rocc_mem_s2_nack,
  input  logic                        rocc_mem_resp_valid,
  input  logic [dcacheReqTagBits-1:0] rocc_mem_resp_bits_tag,
  input  logic [xLen-1:0]             rocc_mem_resp_bits_data,
  output logic                        rocc_busy,
  output logic                        rocc_interrupt
);

  localparam int AW = coreMaxAddrBits;
  localparam int TW = dcacheReqTagBits;
  localparam int SW = $clog2(MAX_OUT);
  localparam logic [6:0] FN_SET_BASE = 7'd0;
  localparam logic [6:0] FN_RUN      = 7'd1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_RESP = 2'd2} state_t;

  // Lowest set bit of a slot vector, returned as {found, index}.
  function automatic logic [SW:0] first_set(input logic [MAX_OUT-1:0] v);
    logic [SW:0] res;
    res = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      res = v[i] ? {1'b1, SW'(i)} : res;
    end
    return res;
  endfunction

  // Byte offset of word number idx (8-byte words).
  function automatic logic [AW-1:0] word_off(input logic [CNT_W-1:0] idx);
    return AW'({idx, 3'b000});
  endfunction

  // One reduction step; mode 3 behaves as unsigned max.
  function automatic logic [xLen-1:0] reduce_step(input logic [xLen-1:0] acc,
                                                  input logic [xLen-1:0] data,
                                                  input logic [1:0]      mode);
    logic [xLen-1:0] res;
    case (mode)
      2'd0:    res = acc + data;
      2'd1:    res = acc ^ data;
      default: res = (data > acc) ? data : acc;
    endcase
    return res;
  endfunction

  // A returning tag is only meaningful if it names a slot that is waiting.
  function automatic logic tag_pending(input logic [TW-1:0]      tag,
                                       input logic [MAX_OUT-1:0] pend);
    return (tag < TW'(MAX_OUT)) && pend[tag[SW-1:0]];
  endfunction

  state_t               r_state, w_state_nxt;
  logic [AW-1:0]        r_base;
  logic [CNT_W-1:0]     r_rem_issue, r_rem_recv, r_issue_idx;
  logic [1:0]           r_mode;
  logic [xLen-1:0]      r_acc;
  logic [4:0]           r_rd;
  logic                 r_xd;
  logic [MAX_OUT-1:0]   r_pend, r_replay;
  logic [AW-1:0]        r_slot_addr [MAX_OUT];
  logic                 r_p1_vld, r_p2_vld;
  logic [SW-1:0]        r_p1_slot, r_p2_slot;
  logic                 r_hold, r_hold_replay;
  logic [SW-1:0]        r_hold_slot;

  logic                 w_cmd_ready, w_resp_valid, w_busy;
  logic                 w_cmd_fire, w_is_run, w_run_zero;
  logic [SW:0]          w_free, w_rpl;
  logic                 w_req_valid, w_req_replay, w_req_fire;
  logic [SW-1:0]        w_req_slot, w_resp_slot;
  logic [AW-1:0]        w_req_addr;
  logic                 w_resp_hit, w_last, w_nack;
  logic                 w_unused;

  assign w_cmd_fire  = rocc_cmd_valid & w_cmd_ready;
  assign w_is_run    = (rocc_cmd_bits_inst_funct == FN_RUN);
  assign w_run_zero  = (rocc_cmd_bits_rs1[CNT_W-1:0] == '0);
  assign w_free      = first_set(~r_pend);
  assign w_rpl       = first_set(r_replay);
  assign w_resp_slot = rocc_mem_resp_bits_tag[SW-1:0];
  assign w_resp_hit  = rocc_mem_resp_valid & (r_state == S_RUN) &
                       tag_pending(rocc_mem_resp_bits_tag, r_pend);
  assign w_last      = w_resp_hit & (r_rem_recv == CNT_W'(1'b1));
  assign w_nack      = rocc_mem_s2_nack & r_p2_vld;
  assign w_req_fire  = w_req_valid & rocc_mem_req_ready;
  assign w_req_addr  = w_req_replay ? r_slot_addr[w_req_slot]
                                    : (r_base + word_off(r_issue_idx));
  assign w_unused    = &{1'b0, rocc_cmd_bits_rs1[xLen-1:AW], rocc_cmd_bits_rs2[xLen-1:2]};

  // Request selection: a stalled request is held, replays beat new issues.
  always_comb begin
    w_req_valid  = 1'b0;
    w_req_replay = 1'b0;
    w_req_slot   = '0;
    if (r_state == S_RUN) begin
      if (r_hold) begin
        w_req_valid  = 1'b1;
        w_req_replay = r_hold_replay;
        w_req_slot   = r_hold_slot;
      end else if (w_rpl[SW]) begin
        w_req_valid  = 1'b1;
        w_req_replay = 1'b1;
        w_req_slot   = w_rpl[SW-1:0];
      end else if ((r_rem_issue != '0) && w_free[SW]) begin
        w_req_valid  = 1'b1;
        w_req_slot   = w_free[SW-1:0];
      end else begin
        w_req_valid  = 1'b0;
      end
    end else begin
      w_req_valid = 1'b0;
    end
  end

  // Next-state and handshake decode of the IDLE/RUN/RESP controller.
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        if (rocc_cmd_valid && w_is_run) begin
          if (w_run_zero) begin
            w_state_nxt = rocc_cmd_bits_inst_xd ? S_RESP : S_IDLE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = r_xd ? S_RESP : S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (rocc_resp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command latch, slot bookkeeping, nack tracking and accumulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_base        <= '0;
      r_rem_issue   <= '0;
      r_rem_recv    <= '0;
      r_issue_idx   <= '0;
      r_mode        <= 2'd0;
      r_acc         <= '0;
      r_rd          <= 5'd0;
      r_xd          <= 1'b0;
      r_pend        <= '0;
      r_replay      <= '0;
      r_p1_vld      <= 1'b0;
      r_p2_vld      <= 1'b0;
      r_p1_slot     <= '0;
      r_p2_slot     <= '0;
      r_hold        <= 1'b0;
      r_hold_replay <= 1'b0;
      r_hold_slot   <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        r_slot_addr[i] <= '0;
      end
    end else begin
      r_p1_vld      <= w_req_fire;
      r_p1_slot     <= w_req_slot;
      r_p2_vld      <= r_p1_vld;
      r_p2_slot     <= r_p1_slot;
      r_hold        <= w_req_valid & ~rocc_mem_req_ready;
      r_hold_replay <= w_req_replay;
      r_hold_slot   <= w_req_slot;
      if (w_cmd_fire) begin
        case (rocc_cmd_bits_inst_funct)
          FN_SET_BASE: r_base <= rocc_cmd_bits_rs1[AW-1:0];
          FN_RUN: begin
            r_rem_issue <= rocc_cmd_bits_rs1[CNT_W-1:0];
            r_rem_recv  <= rocc_cmd_bits_rs1[CNT_W-1:0];
            r_issue_idx <= '0;
            r_mode      <= rocc_cmd_bits_rs2[1:0];
            r_rd        <= rocc_cmd_bits_inst_rd;
            r_xd        <= rocc_cmd_bits_inst_xd;
            r_acc       <= '0;
          end
          default: ;
        endcase
      end
      if (w_resp_hit) begin
        r_acc                <= reduce_step(r_acc, rocc_mem_resp_bits_data, r_mode);
        r_pend[w_resp_slot]  <= 1'b0;
        r_rem_recv           <= r_rem_recv - CNT_W'(1'b1);
      end
      if (w_last) begin
        r_base <= r_base + word_off(r_issue_idx);
      end
      if (w_req_fire) begin
        r_pend[w_req_slot] <= 1'b1;
        if (w_req_replay) begin
          r_replay[w_req_slot] <= 1'b0;
        end else begin
          r_slot_addr[w_req_slot] <= w_req_addr;
          r_rem_issue             <= r_rem_issue - CNT_W'(1'b1);
          r_issue_idx             <= r_issue_idx + CNT_W'(1'b1);
        end
      end
      if (w_nack) begin
        r_replay[r_p2_slot] <= 1'b1;
      end
    end
  end

  assign rocc_cmd_ready             = w_cmd_ready;
  assign rocc_resp_valid            = w_resp_valid;
  assign rocc_resp_bits_rd          = r_rd;
  assign rocc_resp_bits_data        = r_acc;
  assign rocc_busy                  = w_busy;
  assign rocc_interrupt             = 1'b0;
  assign rocc_mem_req_valid         = w_req_valid;
  assign rocc_mem_req_bits_addr     = w_req_addr;
  assign rocc_mem_req_bits_tag      = TW'(w_req_slot);
  assign rocc_mem_req_bits_cmd      = 5'b00000;
  assign rocc_mem_req_bits_size     = 2'b11;
  assign rocc_mem_req_bits_signed   = 1'b0;
  assign rocc_mem_req_bits_phys     = 1'b0;
  assign rocc_mem_req_bits_no_alloc = 1'b0;
  assign rocc_mem_req_bits_no_xcpt  = 1'b0;

endmodule

// File: tb/tb_rocc_vec_reduce.sv
// Testbench for rocc_vec_reduce: randomized vectors served by a behavioural
// memory (random latency, out-of-order returns, back-pressure, nacks) and
// checked against a plain-arithmetic reduction of the same word list.
module tb_rocc_vec_reduce;
  localparam int XLEN = 64, AW = 40, TW = 9, MAX_OUT = 4, CNT_W = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            rocc_cmd_valid = 1'b0, rocc_cmd_ready;
  logic [6:0]      rocc_cmd_bits_inst_funct = 7'd0;
  logic [4:0]      rocc_cmd_bits_inst_rd = 5'd0;
  logic            rocc_cmd_bits_inst_xd = 1'b0;
  logic [63:0]     rocc_cmd_bits_rs1 = 64'd0, rocc_cmd_bits_rs2 = 64'd0;
  logic            rocc_resp_valid, rocc_resp_ready = 1'b0;
  logic [4:0]      rocc_resp_bits_rd;
  logic [63:0]     rocc_resp_bits_data;
  logic            rocc_mem_req_valid, rocc_mem_req_ready = 1'b0;
  logic [AW-1:0]   rocc_mem_req_bits_addr;
  logic [TW-1:0]   rocc_mem_req_bits_tag;
  logic [4:0]      rocc_mem_req_bits_cmd;
  logic [1:0]      rocc_mem_req_bits_size;
  logic            rocc_mem_req_bits_signed, rocc_mem_req_bits_phys;
  logic            rocc_mem_req_bits_no_alloc, rocc_mem_req_bits_no_xcpt;
  logic            rocc_mem_s2_nack = 1'b0, rocc_mem_resp_valid = 1'b0;
  logic [TW-1:0]   rocc_mem_resp_bits_tag = '0;
  logic [63:0]     rocc_mem_resp_bits_data = 64'd0;
  logic            rocc_busy, rocc_interrupt;

  rocc_vec_reduce dut (
    .clock(clock), .reset(reset),
    .rocc_cmd_valid(rocc_cmd_valid), .rocc_cmd_ready(rocc_cmd_ready),
    .rocc_cmd_bits_inst_funct(rocc_cmd_bits_inst_funct),
    .rocc_cmd_bits_inst_rd(rocc_cmd_bits_inst_rd),
    .rocc_cmd_bits_inst_xd(rocc_cmd_bits_inst_xd),
    .rocc_cmd_bits_rs1(rocc_cmd_bits_rs1), .rocc_cmd_bits_rs2(rocc_cmd_bits_rs2),
    .rocc_resp_valid(rocc_resp_valid), .rocc_resp_ready(rocc_resp_ready),
    .rocc_resp_bits_rd(rocc_resp_bits_rd), .rocc_resp_bits_data(rocc_resp_bits_data),
    .rocc_mem_req_valid(rocc_mem_req_valid), .rocc_mem_req_ready(rocc_mem_req_ready),
    .rocc_mem_req_bits_addr(rocc_mem_req_bits_addr), .rocc_mem_req_bits_tag(rocc_mem_req_bits_tag),
    .rocc_mem_req_bits_cmd(rocc_mem_req_bits_cmd), .rocc_mem_req_bits_size(rocc_mem_req_bits_size),
    .rocc_mem_req_bits_signed(rocc_mem_req_bits_signed), .rocc_mem_req_bits_phys(rocc_mem_req_bits_phys),
    .rocc_mem_req_bits_no_alloc(rocc_mem_req_bits_no_alloc),
    .rocc_mem_req_bits_no_xcpt(rocc_mem_req_bits_no_xcpt),
    .rocc_mem_s2_nack(rocc_mem_s2_nack), .rocc_mem_resp_valid(rocc_mem_resp_valid),
    .rocc_mem_resp_bits_tag(rocc_mem_resp_bits_tag), .rocc_mem_resp_bits_data(rocc_mem_resp_bits_data),
    .rocc_busy(rocc_busy), .rocc_interrupt(rocc_interrupt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory model state.
  typedef struct { logic [AW-1:0] addr; logic [TW-1:0] tag; int fcyc; bit nack; } fire_t;
  fire_t         outq[$];
  logic [TW-1:0] stale_tags[$];
  logic [63:0]   words [0:31];
  int            rd_cnt [0:31];
  logic [AW-1:0] vbase = '0;
  int            vcount = 0, fire_no = 0, nack_nth = 0, nack_pct = 0;
  int            ready_mode = 0, last_resp_cyc = 0;
  bit            reverse_mode = 0, hold_resp = 0, send_stale = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [TW-1:0] prev_tag;

  // Behavioural L1: drives inputs at negedge, records fires that happen at the next posedge.
  always @(negedge clock) begin : mem_model
    int pick, idx;
    logic [AW-1:0] off;
    bit inr, dup, nk;
    if (reset) begin
      rocc_mem_req_ready = 1'b0; rocc_mem_s2_nack = 1'b0; rocc_mem_resp_valid = 1'b0;
      rocc_mem_resp_bits_tag = '0; rocc_mem_resp_bits_data = 64'd0;
      outq.delete(); prev_stall = 0;
    end else begin
      rocc_mem_s2_nack = 1'b0; rocc_mem_resp_valid = 1'b0;
      for (int i = 0; i < outq.size(); i++) begin
        if (outq[i].nack && (outq[i].fcyc + 2 == cyc)) begin
          rocc_mem_s2_nack = 1'b1; outq.delete(i); break;
        end
      end
      pick = -1;
      if (send_stale && stale_tags.size() > 0) begin
        rocc_mem_resp_valid = 1'b1;
        rocc_mem_resp_bits_tag = stale_tags.pop_front();
        rocc_mem_resp_bits_data = 64'hDEAD_0000_BEEF;
      end else if (!hold_resp) begin
        for (int i = 0; i < outq.size(); i++)
          if (!outq[i].nack && outq[i].fcyc + 2 <= cyc && (reverse_mode || pick < 0)) pick = i;
        if (pick >= 0 && !reverse_mode && $urandom_range(0, 9) < 3) pick = -1;
        if (pick >= 0) begin
          off = outq[pick].addr - vbase;
          idx = int'(off >> 3) & 31;
          rocc_mem_resp_valid = 1'b1;
          rocc_mem_resp_bits_tag = outq[pick].tag;
          rocc_mem_resp_bits_data = words[idx];
          outq.delete(pick);
          last_resp_cyc = cyc;
        end
      end
      case (ready_mode)
        0: rocc_mem_req_ready = 1'b1;
        1: rocc_mem_req_ready = (cyc % 2) == 1;
        default: rocc_mem_req_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (prev_stall) begin
        check_eq("req_held_valid", 64'(rocc_mem_req_valid), 64'd1);
        check_eq("req_held_addr", 64'(rocc_mem_req_bits_addr), 64'(prev_addr));
        check_eq("req_held_tag", 64'(rocc_mem_req_bits_tag), 64'(prev_tag));
      end
      if (rocc_mem_req_valid && rocc_mem_req_ready) begin
        off = rocc_mem_req_bits_addr - vbase;
        inr = (off[2:0] == 3'b000) && ((off >> 3) < AW'(vcount));
        idx = int'(off >> 3) & 31;
        dup = 0;
        foreach (outq[i]) if (outq[i].tag == rocc_mem_req_bits_tag) dup = 1;
        check_eq("req_addr_in_range", 64'(inr), 64'd1);
        check_eq("req_tag_free", 64'(dup), 64'd0);
        check_eq("outstanding_le_max", 64'(outq.size() < MAX_OUT), 64'd1);
        fire_no++;
        nk = (fire_no == nack_nth) || ($urandom_range(0, 99) < nack_pct);
        if (!nk && inr) rd_cnt[idx]++;
        outq.push_back('{rocc_mem_req_bits_addr, rocc_mem_req_bits_tag, cyc, nk});
      end
      prev_stall = rocc_mem_req_valid && !rocc_mem_req_ready;
      prev_addr = rocc_mem_req_bits_addr;
      prev_tag = rocc_mem_req_bits_tag;
    end
  end

  // Reference reduction over the current word list.
  function automatic logic [63:0] ref_reduce(input int n, input int mode);
    logic [63:0] e;
    e = 64'd0;
    for (int i = 0; i < n; i++) begin
      if (mode == 0) e = e + words[i];
      else if (mode == 1) e = e ^ words[i];
      else if (words[i] > e) e = words[i];
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic send_cmd(input logic [6:0] fn, input logic [4:0] rd, input bit xd,
                          input logic [63:0] rs1, input logic [63:0] rs2);
    check_eq("cmd_ready_idle", 64'(rocc_cmd_ready), 64'd1);
    rocc_cmd_bits_inst_funct = fn; rocc_cmd_bits_inst_rd = rd; rocc_cmd_bits_inst_xd = xd;
    rocc_cmd_bits_rs1 = rs1; rocc_cmd_bits_rs2 = rs2; rocc_cmd_valid = 1'b1;
    tick();
    rocc_cmd_valid = 1'b0;
  endtask

  task automatic set_base(input logic [AW-1:0] b);
    send_cmd(7'd0, 5'd0, 1'b0, 64'(b), 64'd0);
    vbase = b;
  endtask

  task automatic run_vec(input int n, input int mode, input bit xd, input logic [4:0] rd);
    logic [63:0] exp;
    bit done, saw_resp;
    exp = ref_reduce(n, mode);
    for (int i = 0; i < 32; i++) rd_cnt[i] = 0;
    vcount = n; fire_no = 0;
    send_cmd(7'd1, rd, xd, 64'(n), 64'(mode));
    check_eq("busy_after_cmd", 64'(rocc_busy), 64'((n > 0) || xd));
    check_eq("cmd_ready_busy", 64'(rocc_cmd_ready), 64'(!((n > 0) || xd)));
    if (n > 0) begin
      check_eq("first_req_1cyc", 64'(rocc_mem_req_valid), 64'd1);
      check_eq("first_req_addr", 64'(rocc_mem_req_bits_addr), 64'(vbase));
    end else if (xd) begin
      check_eq("zero_cnt_resp_1cyc", 64'(rocc_resp_valid), 64'd1);
    end
    done = 0; saw_resp = 0;
    for (int b = 0; b < 3000; b++) begin
      if (!xd && rocc_resp_valid) saw_resp = 1;
      if (xd ? rocc_resp_valid : !rocc_busy) begin done = 1; break; end
      tick();
    end
    check_eq("run_done", 64'(done), 64'd1);
    if (done && n > 0) check_eq("done_latency", 64'(cyc - last_resp_cyc), 64'd1);
    if (xd) begin
      for (int h = 0; h < 2; h++) begin
        check_eq("resp_valid_held", 64'(rocc_resp_valid), 64'd1);
        check_eq("resp_rd", 64'(rocc_resp_bits_rd), 64'(rd));
        check_eq("resp_data", rocc_resp_bits_data, exp);
        tick();
      end
      rocc_resp_ready = 1'b1;
      tick();
      rocc_resp_ready = 1'b0;
      check_eq("resp_cleared", 64'(rocc_resp_valid), 64'd0);
      check_eq("busy_cleared", 64'(rocc_busy), 64'd0);
    end else begin
      check_eq("no_resp_when_xd0", 64'(saw_resp), 64'd0);
    end
    for (int i = 0; i < n; i++) check_eq("word_read_once", 64'(rd_cnt[i]), 64'd1);
    check_eq("nothing_outstanding", 64'(outq.size()), 64'd0);
    vbase = vbase + AW'(8 * n);
    nack_nth = 0; nack_pct = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, 64'(rocc_cmd_ready), 64'd1);
    check_eq({tag, "_resp_valid"}, 64'(rocc_resp_valid), 64'd0);
    check_eq({tag, "_req_valid"}, 64'(rocc_mem_req_valid), 64'd0);
    check_eq({tag, "_busy"}, 64'(rocc_busy), 64'd0);
    check_eq({tag, "_interrupt"}, 64'(rocc_interrupt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 32; i++) words[i] = 64'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("reset");
    check_eq("req_cmd", 64'(rocc_mem_req_bits_cmd), 64'd0);
    check_eq("req_size", 64'(rocc_mem_req_bits_size), 64'd3);
    check_eq("req_flags", 64'({rocc_mem_req_bits_signed, rocc_mem_req_bits_phys,
                               rocc_mem_req_bits_no_alloc, rocc_mem_req_bits_no_xcpt}), 64'd0);
    check_eq("reset_acc", rocc_resp_bits_data, 64'd0);

    // Directed vectors.
    set_base(40'h1000);
    words[0] = 64'd1; words[1] = 64'd2; words[2] = 64'd3; words[3] = 64'd4;
    run_vec(4, 0, 1'b1, 5'd5);
    set_base(40'h2000);
    words[0] = 64'hFF; words[1] = 64'h0F;
    run_vec(2, 1, 1'b1, 5'd3);
    words[0] = 64'h1; words[1] = 64'hFFFF_FFFF_FFFF_FFFF; words[2] = 64'h7;
    run_vec(3, 2, 1'b1, 5'd9);
    words[0] = 64'hFFFF_FFFF_FFFF_FFFF; words[1] = 64'd2;
    run_vec(2, 0, 1'b1, 5'd31);
    words[0] = 64'h10; words[1] = 64'h8000_0000_0000_0000; words[2] = 64'h3;
    run_vec(3, 3, 1'b1, 5'd1);

    // Ten words, reversed returns, ready every other cycle.
    set_base(40'h8000);
    for (int i = 0; i < 10; i++) words[i] = {$urandom(), $urandom()};
    ready_mode = 1; reverse_mode = 1;
    run_vec(10, 0, 1'b1, 5'd12);
    ready_mode = 0; reverse_mode = 0;

    // Second request nacked.
    for (int i = 0; i < 4; i++) words[i] = 64'(i + 100);
    nack_nth = 2;
    run_vec(4, 0, 1'b1, 5'd6);

    // Zero-count and no-response runs.
    run_vec(0, 0, 1'b1, 5'd7);
    run_vec(0, 1, 1'b0, 5'd8);
    for (int i = 0; i < 5; i++) words[i] = {$urandom(), $urandom()};
    run_vec(5, 1, 1'b0, 5'd2);

    // Randomized runs.
    for (int t = 0; t < 16; t++) begin
      int n;
      n = $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) set_base(AW'($urandom_range(1, 4095)) << 3);
      for (int i = 0; i < n; i++)
        words[i] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom(), $urandom()};
      ready_mode = $urandom_range(0, 2);
      reverse_mode = ($urandom_range(0, 1) == 1);
      nack_pct = $urandom_range(0, 25);
      run_vec(n, $urandom_range(0, 3), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
    end
    ready_mode = 0; reverse_mode = 0;

    // Reset with loads outstanding, then stale returns.
    set_base(40'h3000);
    for (int i = 0; i < 8; i++) words[i] = 64'(i + 1);
    vcount = 8; fire_no = 0; hold_resp = 1;
    send_cmd(7'd1, 5'd4, 1'b1, 64'd8, 64'd0);
    ok = 0;
    for (int b = 0; b < 50; b++) begin
      if (outq.size() >= 3) begin ok = 1; break; end
      tick();
    end
    check_eq("three_outstanding", 64'(ok), 64'd1);
    foreach (outq[i]) stale_tags.push_back(outq[i].tag);
    reset = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    tick();
    reset = 1'b0;
    hold_resp = 0; send_stale = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("stale_busy", 64'(rocc_busy), 64'd0);
      check_eq("stale_resp_valid", 64'(rocc_resp_valid), 64'd0);
    end
    send_stale = 0;
    check_idle_outputs("after_stale");
    check_eq("acc_after_reset", rocc_resp_bits_data, 64'd0);
    vbase = '0;
    for (int i = 0; i < 3; i++) words[i] = 64'(i * 7 + 5);
    run_vec(3, 0, 1'b1, 5'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
